// File: rtl/hex_scan_ctrl.sv
// +--------------------------------------------------------------------------+
// | hex_scan_ctrl: multiplexed 7-segment hex scanner with frame-aligned      |
// | double-buffered display word. Optional macro: LEAD_ZERO_BLANK_EN.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module hex_scan_ctrl #(
    parameter int DIGITS    = 4,
    parameter int DIV       = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    output logic                  ready,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int CNT_MAX = (DIV > BLANK_CYC) ? ((DIV > 2) ? DIV : 2)
                                               : ((BLANK_CYC > 2) ? BLANK_CYC : 2);
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

    localparam logic [0:0] BLANK = 1'b0;
    localparam logic [0:0] SHOW  = 1'b1;

    logic [0:0]          state;
    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] shadow;
    logic [4*DIGITS-1:0] staging;
    logic                pending;

    logic                slot_end;
    logic                wrap;
    logic [IDX_W-1:0]    idx_next;
    logic [4*DIGITS-1:0] shadow_next;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    function automatic logic [6:0] digit_seg(input logic [4*DIGITS-1:0] word,
                                             input logic [IDX_W-1:0]    d);
        logic [6:0] s;
        s = decode(4'(word >> (4 * d)));
`ifdef LEAD_ZERO_BLANK_EN
        // Digit 0 always shows, so an all-zero word still reads "0".
        if (d != '0 && (word >> (4 * d)) == '0) begin
            s = 7'h7F;
        end
`endif
        return s;
    endfunction

    assign slot_end    = (state == SHOW) && (cnt == DIV_LAST);
    assign wrap        = slot_end && (idx == IDX_LAST);
    assign idx_next    = wrap ? '0 : idx + 1'b1;
    // The first slot of a new frame must already see the committed word.
    assign shadow_next = (wrap && pending) ? staging : shadow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= BLANK;
            cnt     <= '0;
            idx     <= '0;
            shadow  <= '0;
            staging <= '0;
            pending <= 1'b0;
            ready   <= 1'b1;
            an      <= '1;
            seg     <= 7'h7F;
        end else begin
            if (load && ready) begin
                staging <= value;
                pending <= 1'b1;
                ready   <= 1'b0;
            end
            if (wrap && pending) begin
                shadow  <= staging;
                pending <= 1'b0;
                ready   <= 1'b1;
            end
            case (state)
                BLANK: begin
                    if (BLANK_CYC == 0 || cnt == BLANK_LAST) begin
                        state <= SHOW;
                        cnt   <= '0;
                        an    <= ~(DIGITS'(1) << idx);
                        seg   <= digit_seg(shadow, idx);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHOW: begin
                    if (slot_end) begin
                        idx <= idx_next;
                        cnt <= '0;
                        if (BLANK_CYC == 0) begin
                            an  <= ~(DIGITS'(1) << idx_next);
                            seg <= digit_seg(shadow_next, idx_next);
                        end else begin
                            state <= BLANK;
                            an    <= '1;
                            seg   <= 7'h7F;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= BLANK;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
